decoder_4b3b: RTL
=================

DECODER_4B3B -- requirements
Module: decoder_4b3b

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8: width of the error counter.
REQ-002 SHALL have parameter LOCK_THRESH, default 16: consecutive error-free symbols needed to acquire lock.
REQ-003 SHALL have parameter LOSS_THRESH, default 4: consecutive erroneous symbols that drop lock.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-low reset.
REQ-006 SHALL have port valid_i  input  1  data_i holds a symbol this cycle.
REQ-007 SHALL have port data_i  input  4  received sub-block {f,g,h,j}; bit3=f, bit0=j.
REQ-008 SHALL have port err_cnt_clr_i  input  1  clears err_cnt_o.
REQ-009 SHALL have port valid_o  output  1  outputs carry a decoded symbol.
REQ-010 SHALL have port data_o  output  3  decoded {H,G,F}; bit2=H.
REQ-011 SHALL have port code_err_o  output  1  symbol is not a legal code.
REQ-012 SHALL have port disp_err_o  output  1  legal code received with the wrong running disparity.
REQ-013 SHALL have port rd_neg_o  output  1  running disparity after the symbol; 1 = negative.
REQ-014 SHALL have port lock_o  output  1  lock FSM is in LOCKED.
REQ-015 SHALL have port err_cnt_o  output  ERR_CNT_W  saturating count of erroneous symbols.

Function
REQ-016 SHALL register every output; latency valid_i to valid_o is exactly 1 cycle; no backpressure.
REQ-017 SHALL decode: 1011/0100->000; 1001->001; 0101->010; 1100/0011->011; 1101/0010->100; 1010->101; 0110->110; 1110/0001/0111/1000->111.
REQ-018 SHALL flag code_err_o for 0000 and 1111, with data_o=000, disp_err_o=0 and RD unchanged.
REQ-019 SHALL classify legal symbols as +2 (three ones), -2 (one one) or neutral (two ones).
REQ-020 SHALL flag disp_err_o for a +2 symbol while RD is positive, or a -2 symbol while RD is negative; data_o still carries the decoded value.
REQ-021 SHALL set RD positive after any +2 symbol and negative after any -2 symbol, including on a disparity error; neutral symbols leave RD unchanged.
REQ-022 SHALL accept both neutral forms of 011 (1100, 0011) at either RD with no error.
REQ-023 SHALL, when valid_i=0, drive valid_o=0, code_err_o=0 and disp_err_o=0 next cycle, hold data_o, and leave RD, counters and FSM unchanged.
REQ-024 SHALL increment err_cnt_o by 1 per valid symbol with code_err or disp_err, counting once if both apply, saturating at all-ones.
REQ-025 SHALL give err_cnt_clr_i priority: the counter reads 0 next cycle even if an erroneous symbol arrives in the same cycle.
REQ-026 SHALL implement a lock FSM with states UNLOCKED and LOCKED, plus run counters good_run and bad_run.
REQ-027 SHALL, in UNLOCKED, increment good_run on each good valid symbol and zero it on a bad one; when a good symbol brings it to LOCK_THRESH, move to LOCKED and zero both counters.
REQ-028 SHALL, in LOCKED, increment bad_run on each bad valid symbol and zero it on a good one; when a bad symbol brings it to LOSS_THRESH, move to UNLOCKED and zero both counters.
REQ-029 SHALL make lock_o change in the same cycle that valid_o asserts for the triggering symbol.
REQ-030 SHALL leave the run counters unaffected by cycles where valid_i=0.

Reset
REQ-031 SHALL, on reset_i=0 at a clock edge, set valid_o=0, data_o=000, code_err_o=0, disp_err_o=0, rd_neg_o=1, lock_o=0, err_cnt_o=0, good_run=bad_run=0 and the FSM to UNLOCKED.
REQ-032 SHALL let reset override any in-flight symbol, clear and FSM transition in the same cycle.

Verification
REQ-033 SHALL cover: release reset, hold valid_i=0 -> all outputs at the REQ-031 values, rd_neg_o=1.
REQ-034 SHALL cover: 1011, 0100, 1110, 0001 from reset -> data_o 000,000,111,111; rd_neg_o 0,1,0,1; no errors.
REQ-035 SHALL cover: 1011, 1011 -> second gives disp_err_o=1, data_o=000, rd_neg_o=0, err_cnt_o=1; then 0000 -> code_err_o=1, rd_neg_o=0, err_cnt_o=2.
REQ-036 SHALL cover: 16 x 1001 with random valid_i gaps -> lock_o rises with the 16th valid_o; then 3 x 1111, 1 x 1001, 4 x 1111 -> lock_o falls only with the last 1111.
REQ-037 SHALL cover: 300 x 0000 -> err_cnt_o stops at 255; err_cnt_clr_i with 0000 in the same cycle -> err_cnt_o=0.
REQ-038 SHALL cover: reset_i=0 during a LOCKED stream with RD positive -> lock_o=0, rd_neg_o=1, err_cnt_o=0 the next cycle.

Source files
------------

// File: rtl/decoder_4b3b.sv
// decoder_4b3b: 4b/3b sub-block decoder with running-disparity check, error counter and lock FSM
module decoder_4b3b #(
    parameter int ERR_CNT_W   = 8,
    parameter int LOCK_THRESH = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic [3:0]           data_i,
    input  logic                 err_cnt_clr_i,
    output logic                 valid_o,
    output logic [2:0]           data_o,
    output logic                 code_err_o,
    output logic                 disp_err_o,
    output logic                 rd_neg_o,
    output logic                 lock_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    localparam int GW = $clog2(LOCK_THRESH + 1);
    localparam int BW = $clog2(LOSS_THRESH + 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t        state;
    logic [GW-1:0] good_run;
    logic [BW-1:0] bad_run;
    logic [2:0]    ones;
    logic [2:0]    dec;
    logic          code_err, pos, neg, disp_err, bad;

    // classify the incoming symbol and check it against the running disparity
    always_comb begin
        ones     = {2'b0, data_i[3]} + {2'b0, data_i[2]} + {2'b0, data_i[1]} + {2'b0, data_i[0]};
        code_err = (ones == 3'd0) || (ones == 3'd4);
        pos      = ones == 3'd3;
        neg      = ones == 3'd1;
        disp_err = (pos && !rd_neg_o) || (neg && rd_neg_o);
        bad      = code_err || disp_err;
    end

    // code-to-data lookup; illegal codes map to 000
    always_comb begin
        dec = 3'd0;
        case (data_i)
            4'b1001:                            dec = 3'd1;
            4'b0101:                            dec = 3'd2;
            4'b1100, 4'b0011:                   dec = 3'd3;
            4'b1101, 4'b0010:                   dec = 3'd4;
            4'b1010:                            dec = 3'd5;
            4'b0110:                            dec = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: dec = 3'd7;
            default:                            dec = 3'd0;
        endcase
    end

    // registered outputs, running disparity, error counter and lock FSM
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            valid_o    <= 1'b0;
            data_o     <= 3'd0;
            code_err_o <= 1'b0;
            disp_err_o <= 1'b0;
            rd_neg_o   <= 1'b1;
            lock_o     <= 1'b0;
            err_cnt_o  <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            state      <= UNLOCKED;
        end else begin
            valid_o    <= valid_i;
            code_err_o <= valid_i && code_err;
            disp_err_o <= valid_i && disp_err;
            if (valid_i) begin
                data_o <= code_err ? 3'd0 : dec;
                if (pos)
                    rd_neg_o <= 1'b0;
                else if (neg)
                    rd_neg_o <= 1'b1;
                if (state == UNLOCKED) begin
                    if (bad)
                        good_run <= '0;
                    else if (good_run == GW'(LOCK_THRESH - 1)) begin
                        state    <= LOCKED;
                        lock_o   <= 1'b1;
                        good_run <= '0;
                        bad_run  <= '0;
                    end else
                        good_run <= good_run + 1'b1;
                end else begin
                    if (!bad)
                        bad_run <= '0;
                    else if (bad_run == BW'(LOSS_THRESH - 1)) begin
                        state    <= UNLOCKED;
                        lock_o   <= 1'b0;
                        good_run <= '0;
                        bad_run  <= '0;
                    end else
                        bad_run <= bad_run + 1'b1;
                end
            end
            if (err_cnt_clr_i)
                err_cnt_o <= '0;
            else if (valid_i && bad && !(&err_cnt_o))
                err_cnt_o <= err_cnt_o + 1'b1;
        end
    end
endmodule
